// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic camera front-end: light codes,
// lockout FSM state encoding and camera bit positions.
package traffic_pkg;

  // One-hot light codes as driven by the intersection controller
  localparam logic [3:0] CT_RED    = 4'b1000;
  localparam logic [3:0] CT_YELLOW = 4'b0100;
  localparam logic [3:0] CT_GREEN  = 4'b0010;
  localparam logic [3:0] CT_LEFT   = 4'b0001;

  // Arrival debounce FSM
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  // Bit positions inside the 2-bit congestion code
  localparam int CAM_DIR0 = 0;
  localparam int CAM_DIR1 = 1;

endpackage

// File: rtl/traffic_queue_lane.sv
// One approach: detector synchronizer, debounce FSM, green departure
// timer, saturating vehicle queue and hysteresis congestion flag.
module traffic_queue_lane
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int HI_TH         = 6,
  parameter int LO_TH         = 2,
  parameter int DEPART_CYCLES = 8,
  parameter int LOCKOUT       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_detect,
  input  logic [3:0]    car_traffic,
  output logic          congested,
  output logic [QW-1:0] queue
);

  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(DEPART_CYCLES - 1);
  localparam logic [LW-1:0] LCK_LOAD = LW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
  localparam logic [QW-1:0] Q_MAX    = '1;

  logic          sync_p0, sync_p1, sync_p2;
  logic          rise;
  lock_state_t   state_q, state_d;
  logic [LW-1:0] lck_cnt_q, lck_cnt_d;
  logic          accept;
  logic          arr_p3;
  logic [TW-1:0] tmr_q;
  logic          green;
  logic          depart;
  logic [QW-1:0] queue_q;
  logic          cong_q;

  // Saturating queue step: simultaneous arrival and departure cancel
  function automatic logic [QW-1:0] queue_next(input logic [QW-1:0] q,
                                               input logic arr,
                                               input logic dep);
    if (arr && !dep) return (q == Q_MAX) ? q : q + QW'(1);
    if (dep && !arr) return (q == '0) ? q : q - QW'(1);
    return q;
  endfunction

  // Hysteresis: set at or above HI_TH, clear at or below LO_TH, else hold
  function automatic logic hyst_next(input logic [QW-1:0] q, input logic cur);
    if (q >= QW'(HI_TH)) return 1'b1;
    if (q <= QW'(LO_TH)) return 1'b0;
    return cur;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: history for rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= car_detect;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

  // Debounce FSM state and lockout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lck_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lck_cnt_q <= lck_cnt_d;
    end
  end

  // Next state: an accepted edge opens a lockout window that counts down to 0
  always_comb begin
    state_d   = state_q;
    lck_cnt_d = lck_cnt_q;
    case (state_q)
      IDLE: begin
        if (rise && (LOCKOUT > 0)) begin
          state_d   = LOCK;
          lck_cnt_d = LCK_LOAD;
        end
      end
      LOCK: begin
        if (lck_cnt_q == '0) state_d = IDLE;
        else                 lck_cnt_d = lck_cnt_q - LW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output: only edges seen while idle count as arrivals
  always_comb begin
    accept = (state_q == IDLE) && rise;
  end

  // Stage p3: registered arrival pulse feeding the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arr_p3 <= 1'b0;
    else     arr_p3 <= accept;
  end

  assign green  = (car_traffic == CT_GREEN);
  assign depart = green && (tmr_q == TMR_LAST);

  // Departure timer: runs only on GREEN, partial counts lost when GREEN ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tmr_q <= '0;
    else if (!green)           tmr_q <= '0;
    else if (tmr_q == TMR_LAST) tmr_q <= '0;
    else                       tmr_q <= tmr_q + TW'(1);
  end

  // Queue counter, updated from the arrival pulse and the timer wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) queue_q <= '0;
    else     queue_q <= queue_next(queue_q, arr_p3, depart);
  end

  // Congestion flag follows the registered queue one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cong_q <= 1'b0;
    else     cong_q <= hyst_next(queue_q, cong_q);
  end

  assign queue     = queue_q;
  assign congested = cong_q;

endmodule

// File: rtl/traffic_camera_encoder.sv
// Two independent approach lanes whose congestion flags form the 2-bit
// traffic_camera code for the intersection controller.
module traffic_camera_encoder
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int HI_TH         = 6,
  parameter int LO_TH         = 2,
  parameter int DEPART_CYCLES = 8,
  parameter int LOCKOUT       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_detect_0,
  input  logic          car_detect_1,
  input  logic [3:0]    car_traffic_0,
  input  logic [3:0]    car_traffic_1,
  output logic [1:0]    traffic_camera,
  output logic [QW-1:0] queue_0,
  output logic [QW-1:0] queue_1
);

  logic cam_0, cam_1;

  traffic_queue_lane #(
    .QW(QW), .HI_TH(HI_TH), .LO_TH(LO_TH),
    .DEPART_CYCLES(DEPART_CYCLES), .LOCKOUT(LOCKOUT)
  ) u_lane_0 (
    .clk         (clk),
    .rst         (rst),
    .car_detect  (car_detect_0),
    .car_traffic (car_traffic_0),
    .congested   (cam_0),
    .queue       (queue_0)
  );

  traffic_queue_lane #(
    .QW(QW), .HI_TH(HI_TH), .LO_TH(LO_TH),
    .DEPART_CYCLES(DEPART_CYCLES), .LOCKOUT(LOCKOUT)
  ) u_lane_1 (
    .clk         (clk),
    .rst         (rst),
    .car_detect  (car_detect_1),
    .car_traffic (car_traffic_1),
    .congested   (cam_1),
    .queue       (queue_1)
  );

  // Place each lane's flag at its camera bit position
  always_comb begin
    traffic_camera           = '0;
    traffic_camera[CAM_DIR0] = cam_0;
    traffic_camera[CAM_DIR1] = cam_1;
  end

endmodule
